// File: rtl/reg_map_wr_port.sv
// Masked single-beat register-map write endpoint with readback and flat export.
// Optional REG_MAP_SHADOW_EN: writes land in a shadow bank, copied to active on commit_strobe.
module reg_map_wr_port #(
    parameter int unsigned NUM_REGS         = 8,
    parameter logic [31:0] CHIRP_PERIOD_RST = 32'd10,
    parameter logic [31:0] REG_ID           = 32'h4B37_0001
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     reg_map_wr_cmd,
    input  logic [7:0]               reg_map_wr_addr,
    input  logic [31:0]              reg_map_wr_data,
    input  logic [31:0]              reg_map_wr_keep,
    output logic                     reg_map_wr_valid,
    output logic                     reg_map_wr_ready,
    output logic [1:0]               reg_map_wr_err,
    input  logic [7:0]               rd_addr,
    output logic [31:0]              rd_data,
    input  logic                     commit_strobe,
    output logic                     cfg_update,
    output logic [7:0]               cfg_update_addr,
    output logic [31:0]              chirp_period,
    output logic [NUM_REGS*32-1:0]   reg_map_flat
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] ID_ADDR = AW'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] keep_q, keep_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          cfg_update_q, cfg_update_d;
    logic [AW-1:0] cfg_addr_q, cfg_addr_d;
    logic [DW-1:0] act_q [NUM_REGS];
    logic [DW-1:0] act_d [NUM_REGS];

    logic          accept_c;
    logic [1:0]    wr_err_c;
    logic [DW-1:0] old_c;
    logic [DW-1:0] new_c;

    function automatic logic [DW-1:0] reset_val(input int unsigned idx);
        if (idx == 0)            return CHIRP_PERIOD_RST;
        if (idx == NUM_REGS - 1) return REG_ID;
        return '0;
    endfunction

`ifdef REG_MAP_SHADOW_EN
    logic [DW-1:0] shd_q [NUM_REGS];
    logic [DW-1:0] shd_d [NUM_REGS];
    logic          diff_c;

    always_comb begin
        diff_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (shd_q[i] != act_q[i]) diff_c = 1'b1;
        end
    end

    // Merge source is the shadow bank so back-to-back uncommitted writes accumulate.
    always_comb begin
        old_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == AW'(i)) old_c = shd_q[i];
        end
    end
`else
    logic commit_unused;
    assign commit_unused = commit_strobe;

    always_comb begin
        old_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == AW'(i)) old_c = act_q[i];
        end
    end
`endif

    assign accept_c = (state_q == S_IDLE) && ready_q && reg_map_wr_cmd;
    assign new_c    = (old_c & ~keep_q) | (data_q & keep_q);

    // Full 8-bit address compare; range error outranks read-only, which outranks empty mask.
    always_comb begin
        if (32'(addr_q) >= NUM_REGS)  wr_err_c = 2'b01;
        else if (addr_q == ID_ADDR)   wr_err_c = 2'b10;
        else if (keep_q == '0)        wr_err_c = 2'b11;
        else                          wr_err_c = 2'b00;
    end

    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == AW'(i)) rd_data_d = act_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        keep_d       = keep_q;
        ready_d      = 1'b0;
        valid_d      = 1'b0;
        err_d        = err_q;
        cfg_update_d = 1'b0;
        cfg_addr_d   = cfg_addr_q;
        act_d        = act_q;
`ifdef REG_MAP_SHADOW_EN
        shd_d        = shd_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = ~accept_c;
                if (accept_c) begin
                    addr_d  = reg_map_wr_addr;
                    data_d  = reg_map_wr_data;
                    keep_d  = reg_map_wr_keep;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                err_d   = wr_err_c;
                state_d = S_RESP;
                if (wr_err_c == 2'b00) begin
                    for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                        if (addr_q == AW'(i)) begin
`ifdef REG_MAP_SHADOW_EN
                            shd_d[i] = new_c;
`else
                            act_d[i] = new_c;
                            if (new_c != act_q[i]) begin
                                cfg_update_d = 1'b1;
                                cfg_addr_d   = addr_q;
                            end
`endif
                        end
                    end
                end
            end
            S_RESP: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef REG_MAP_SHADOW_EN
        // Commit copies the pre-write shadow; a same-cycle write waits for the next commit.
        if (commit_strobe) begin
            act_d = shd_q;
            if (diff_c) begin
                cfg_update_d = 1'b1;
                cfg_addr_d   = 8'hFF;
            end
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            keep_q       <= '0;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 2'b00;
            rd_data_q    <= '0;
            cfg_update_q <= 1'b0;
            cfg_addr_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                act_q[i] <= reset_val(i);
`ifdef REG_MAP_SHADOW_EN
                shd_q[i] <= reset_val(i);
`endif
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
            cfg_update_q <= cfg_update_d;
            cfg_addr_q   <= cfg_addr_d;
            act_q        <= act_d;
`ifdef REG_MAP_SHADOW_EN
            shd_q        <= shd_d;
`endif
        end
    end

    always_comb begin
        reg_map_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_map_flat[i*DW +: DW] = act_q[i];
        end
    end

    assign reg_map_wr_valid = valid_q;
    assign reg_map_wr_ready = ready_q;
    assign reg_map_wr_err   = err_q;
    assign rd_data          = rd_data_q;
    assign cfg_update       = cfg_update_q;
    assign cfg_update_addr  = cfg_addr_q;
    assign chirp_period     = act_q[0];

endmodule

// File: tb/tb_reg_map_wr_port.sv
// Bench for reg_map_wr_port: directed scenarios plus random traffic against a transaction-level model.
module tb_reg_map_wr_port;

    localparam int unsigned NR = 8;
    localparam logic [31:0] ID_VAL = 32'h4B37_0001;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd = 1'b0;
    logic [7:0]    waddr = 8'd0;
    logic [31:0]   wdata = 32'd0;
    logic [31:0]   wkeep = 32'd0;
    logic [7:0]    rd_addr = 8'd0;
    logic          commit = 1'b0;

    logic          valid, ready, cfg_update;
    logic [1:0]    err;
    logic [31:0]   rd_data, chirp;
    logic [7:0]    cfg_addr;
    logic [NR*32-1:0] flat;

    reg_map_wr_port dut (
        .aclk             (aclk),
        .areset           (areset),
        .reg_map_wr_cmd   (cmd),
        .reg_map_wr_addr  (waddr),
        .reg_map_wr_data  (wdata),
        .reg_map_wr_keep  (wkeep),
        .reg_map_wr_valid (valid),
        .reg_map_wr_ready (ready),
        .reg_map_wr_err   (err),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .commit_strobe    (commit),
        .cfg_update       (cfg_update),
        .cfg_update_addr  (cfg_addr),
        .chirp_period     (chirp),
        .reg_map_flat     (flat)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Transaction model: a command accepted at edge N commits at N+1, responds at N+2, re-arms at N+3.
    logic [31:0] m_regs [NR];
    logic        m_ready, m_valid, m_cfg;
    logic [1:0]  m_err;
    logic [7:0]  m_cfg_addr;
    logic [31:0] m_rd;
    int          age;
    logic [7:0]  p_addr;
    logic [31:0] p_data, p_keep;

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
        m_regs[0] = 32'd10;
        m_regs[NR-1] = ID_VAL;
        m_ready = 1'b0; m_valid = 1'b0; m_cfg = 1'b0;
        m_err = 2'b00; m_cfg_addr = 8'd0; m_rd = 32'd0;
        age = -1;
    endtask

    initial begin : model
        logic [31:0] nv;
        m_reset();
        forever begin
            @(posedge aclk or posedge areset);
            if (areset) begin
                m_reset();
            end else begin
                m_rd = (int'(rd_addr) < NR) ? m_regs[rd_addr[2:0]] : 32'd0;
                m_valid = 1'b0;
                m_cfg   = 1'b0;
                if (age < 0) begin
                    if (m_ready && cmd) begin
                        p_addr = waddr; p_data = wdata; p_keep = wkeep;
                        age = 0; m_ready = 1'b0;
                    end else begin
                        m_ready = 1'b1;
                    end
                end else if (age == 0) begin
                    if (int'(p_addr) >= NR)          m_err = 2'b01;
                    else if (int'(p_addr) == NR - 1) m_err = 2'b10;
                    else if (p_keep == 32'd0)        m_err = 2'b11;
                    else begin
                        m_err = 2'b00;
                        nv = (m_regs[p_addr[2:0]] & ~p_keep) | (p_data & p_keep);
                        if (nv != m_regs[p_addr[2:0]]) begin
                            m_cfg = 1'b1;
                            m_cfg_addr = p_addr;
                        end
                        m_regs[p_addr[2:0]] = nv;
                    end
                    age = 1;
                end else if (age == 1) begin
                    m_valid = 1'b1;
                    age = 2;
                end else begin
                    m_ready = 1'b1;
                    age = -1;
                end
            end
        end
    end

    // Every falling edge: DUT outputs against the model.
    initial begin : compare
        logic [NR*32-1:0] m_flat;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < NR; i++) m_flat[i*32 +: 32] = m_regs[i];
            chk("ready", 256'(ready), 256'(m_ready));
            chk("valid", 256'(valid), 256'(m_valid));
            chk("err", 256'(err), 256'(m_err));
            chk("cfg_update", 256'(cfg_update), 256'(m_cfg));
            chk("cfg_update_addr", 256'(cfg_addr), 256'(m_cfg_addr));
            chk("chirp_period", 256'(chirp), 256'(m_regs[0]));
            chk("reg_map_flat", 256'(flat), 256'(m_flat));
            chk("rd_data", 256'(rd_data), 256'(m_rd));
        end
    end

    // Waits (bounded) for ready at a falling edge, then strobes one command.
    task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [31:0] k);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) begin
            n_chk++;
            $display("FAIL issue_timeout: ready stayed %b, expected 1", ready);
        end
        cmd = 1'b1; waddr = a; wdata = d; wkeep = k;
        @(negedge aclk);
        cmd = 1'b0;
    endtask

    task automatic err_case(input string nm, input logic [7:0] a, input logic [31:0] k,
                            input logic [1:0] e);
        issue(a, 32'hDEAD_BEEF, k);
        @(negedge aclk);
        chk({nm, "_no_cfg"}, 256'(cfg_update), 256'(1'b0));
        @(negedge aclk);
        chk({nm, "_valid"}, 256'(valid), 256'(1'b1));
        chk({nm, "_err"}, 256'(err), 256'(e));
        chk({nm, "_flat"}, 256'(flat), {32'h4B37_0001, 192'd0, 32'h0000_00FA});
        chk({nm, "_rd7"}, 256'(rd_data), 256'(ID_VAL));
        @(negedge aclk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int vc;
        logic [31:0] last_d;
        repeat (3) @(negedge aclk);
        chk("rst_ready", 256'(ready), 256'(1'b0));
        chk("rst_chirp", 256'(chirp), 256'(32'd10));
        chk("rst_id", 256'(flat[255:224]), 256'(ID_VAL));
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("first_ready", 256'(ready), 256'(1'b1));

        // Full write of reg 0 and its timing.
        issue(8'd0, 32'd1, 32'hFFFF_FFFF);
        chk("t1_busy", 256'(ready), 256'(1'b0));
        @(negedge aclk);
        chk("t1_chirp", 256'(chirp), 256'(32'd1));
        chk("t1_cfg", 256'(cfg_update), 256'(1'b1));
        chk("t1_cfg_addr", 256'(cfg_addr), 256'(8'd0));
        @(negedge aclk);
        chk("t1_valid", 256'(valid), 256'(1'b1));
        chk("t1_err", 256'(err), 256'(2'b00));
        @(negedge aclk);
        chk("t1_ready_back", 256'(ready), 256'(1'b1));

        // Masked write, then the identical write.
        issue(8'd0, 32'h0000_000A, 32'hFFFF_FFFF);
        repeat (3) @(negedge aclk);
        issue(8'd0, 32'hFFFF_FFFF, 32'h0000_00F0);
        @(negedge aclk);
        chk("t2_chirp", 256'(chirp), 256'(32'h0000_00FA));
        chk("t2_model", 256'(m_regs[0]), 256'(32'h0000_00FA));
        chk("t2_cfg", 256'(cfg_update), 256'(1'b1));
        repeat (2) @(negedge aclk);
        issue(8'd0, 32'hFFFF_FFFF, 32'h0000_00F0);
        @(negedge aclk);
        chk("t2_same_no_cfg", 256'(cfg_update), 256'(1'b0));
        @(negedge aclk);
        chk("t2_same_valid", 256'(valid), 256'(1'b1));
        chk("t2_same_err", 256'(err), 256'(2'b00));
        @(negedge aclk);

        // Error classes leave the register file untouched.
        rd_addr = 8'd7;
        err_case("e_addr8", 8'd8, 32'hFFFF_FFFF, 2'b01);
        err_case("e_addr7", 8'd7, 32'hFFFF_FFFF, 2'b10);
        err_case("e_keep0", 8'd3, 32'h0000_0000, 2'b11);
        err_case("e_addrFF", 8'hFF, 32'hFFFF_FFFF, 2'b01);

        // Command while busy is dropped.
        while (ready !== 1'b1) @(negedge aclk);
        cmd = 1'b1; waddr = 8'd1; wdata = 32'd5; wkeep = 32'hFFFF_FFFF;
        @(negedge aclk);
        waddr = 8'd2; wdata = 32'd9;
        @(negedge aclk);
        cmd = 1'b0;
        vc = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid === 1'b1) vc++;
            @(negedge aclk);
        end
        chk("busy_one_valid", 256'(vc), 256'(1));
        chk("busy_flat", 256'(flat), {32'h4B37_0001, 160'd0, 32'd5, 32'h0000_00FA});

        // Reset while the write is pending.
        issue(8'd0, 32'd1, 32'hFFFF_FFFF);
        #1 areset = 1'b1;
        vc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            if (valid === 1'b1) vc++;
        end
        chk("rst_mid_no_valid", 256'(vc), 256'(0));
        chk("rst_mid_chirp", 256'(chirp), 256'(32'd10));
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_mid_ready", 256'(ready), 256'(1'b1));
        chk("rst_mid_chirp2", 256'(chirp), 256'(32'd10));

        // Random traffic; the compare process carries the checking.
        last_d = 32'd0;
        for (int c = 0; c < 1500; c++) begin
            int r;
            @(negedge aclk);
            r = int'($urandom_range(0, 9));
            rd_addr = (r == 9) ? 8'($urandom_range(8, 255)) : 8'(r);
            commit = 1'($urandom_range(0, 1));
            cmd = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 11));
            waddr = (r < 9) ? 8'(r) : ((r == 9) ? 8'hFF : 8'($urandom_range(9, 254)));
            r = int'($urandom_range(0, 3));
            wdata = (r == 0) ? last_d : ((r == 1) ? 32'hFFFF_FFFF : $urandom());
            last_d = wdata;
            r = int'($urandom_range(0, 5));
            wkeep = (r == 0) ? 32'd0 : ((r == 1) ? 32'hFFFF_FFFF :
                    ((r == 2) ? (32'd1 << $urandom_range(0, 31)) : $urandom()));
            if ($urandom_range(0, 299) == 0) begin
                #1 areset = 1'b1;
                @(negedge aclk);
                #1 areset = 1'b0;
            end
        end
        cmd = 1'b0;
        commit = 1'b0;
        repeat (5) @(negedge aclk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_map_wr_port.md
Name: reg_map_wr_port

Overview:
- Register-map write endpoint directly downstream of the DIP-switch command generator.
- Accepts single-beat masked write commands (`reg_map_wr_cmd` / `addr` / `data` / `keep`) and applies them to a small 32-bit register file.
- Returns a `ready` / `valid` / `err` handshake to the generator.
- Exports register contents (chirp period, flat bus, readback port) to the chirp/ADC control logic.

Parameters:
- NUM_REGS, 8: number of 32-bit registers; legal addresses 0..NUM_REGS-1.
- CHIRP_PERIOD_RST, 32'd10: reset value of register 0 (chirp period, seconds).
- REG_ID, 32'h4B37_0001: constant value of read-only register NUM_REGS-1.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- reg_map_wr_cmd  in  1  one-cycle write request strobe.
- reg_map_wr_addr  in  8  register address.
- reg_map_wr_data  in  32  write data.
- reg_map_wr_keep  in  32  per-bit write mask (1 = bit is written).
- reg_map_wr_valid  out  1  one-cycle completion pulse.
- reg_map_wr_ready  out  1  high when a command can be accepted.
- reg_map_wr_err  out  2  completion status, meaningful while valid=1.
- rd_addr  in  8  readback address.
- rd_data  out  32  registered readback data.
- commit_strobe  in  1  shadow-to-active transfer pulse (optional feature only).
- cfg_update  out  1  one-cycle pulse when an active register changes.
- cfg_update_addr  out  8  address of the changed register.
- chirp_period  out  32  active register 0.
- reg_map_flat  out  NUM_REGS*32  all active registers; reg i at bits [32i+31:32i].

Behaviour:
- **Reset values.** While areset=1: reg 0 = CHIRP_PERIOD_RST, regs 1..NUM_REGS-2 = 0, reg NUM_REGS-1 = REG_ID. All outputs 0: ready, valid, err, rd_data, cfg_update, cfg_update_addr. FSM goes to IDLE.
- **First ready.** reg_map_wr_ready rises on the first aclk edge after areset deasserts.
- **FSM states:** IDLE, WRITE, RESP.
- **IDLE:** ready=1. On reg_map_wr_cmd=1, latch addr/data/keep, drive ready<=0, go to WRITE.
- **WRITE:** classify the latched command. Priority order (first match wins):
  - addr >= NUM_REGS → err 2'b01.
  - addr == NUM_REGS-1 → err 2'b10 (read-only).
  - keep == 0 → err 2'b11.
  - otherwise err 2'b00.
  - On err 00: reg[addr] <= (reg & ~keep) | (data & keep).
  - On err 00 with a changed value: pulse cfg_update=1 and set cfg_update_addr=addr in the same cycle the register updates.
  - An identical-value write completes with err 00 and no cfg_update.
  - Go to RESP.
- **RESP:** valid=1 for exactly one cycle with err held; next state IDLE, with ready=1 the following cycle.
- **Latency:** cmd sampled at edge N → register updated at edge N+1 → valid high during cycle after edge N+2 → ready high again after edge N+3. Sustained throughput is 1 command per 3 cycles.
- **Busy commands:** reg_map_wr_cmd asserted while ready=0 is ignored (no latch, no response).
- **Outputs between responses:** err holds its last value when valid=0.
- **Address width:** all 8 address bits are compared; no truncation or wrap. Address 8'hFF with NUM_REGS=8 gives err 01.
- **Readback:** rd_data <= active reg[rd_addr] every cycle (1-cycle latency); rd_data=0 for rd_addr >= NUM_REGS.
- **Mid-operation reset:** areset asserted in any state aborts immediately. The pending write is discarded if not yet applied, no valid pulse is produced, and all registers return to reset values.

Optional Feature:
- **Macro:** REG_MAP_SHADOW_EN.
- **Defined:**
  - The WRITE state updates a shadow copy only; cfg_update does not fire at WRITE.
  - On commit_strobe=1, all shadow registers copy to active in one cycle, and cfg_update pulses next cycle with cfg_update_addr = 8'hFF if any active value changed.
  - commit_strobe coincident with a WRITE-state update commits the pre-write shadow; the new write waits for the next commit.
  - rd_data returns active values.
- **Not defined:** commit_strobe is ignored; writes take effect at WRITE as described above.

Test Plan:
- Reset then cmd addr=0, data=1, keep=FFFFFFFF → chirp_period=1 one edge later; valid pulse with err=00; cfg_update=1 with cfg_update_addr=0; ready back high 3 cycles after cmd.
- reg0=0000_000A, cmd addr=0, data=FFFF_FFFF, keep=0000_00F0 → reg0=0000_00FA, err=00; repeating the same command gives err=00 and no cfg_update.
- cmd addr=8 (NUM_REGS=8) → err=01; cmd addr=7 → err=10, rd_data at rd_addr=7 stays 4B37_0001; cmd keep=0 → err=11; no register changes in any case.
- Second cmd issued one cycle after the first (ready=0) → exactly one valid pulse, only the first write applied.
- areset pulsed during WRITE of addr=0, data=1 → no valid; chirp_period=10 after reset; ready high on the first edge after release.
- With REG_MAP_SHADOW_EN: write addr=0, data=1 → chirp_period stays 10 and rd_data=10; commit_strobe → chirp_period=1, then cfg_update with addr FF.
